// File: rtl/bcd_disp_arbiter.sv
// -----------------------------------------------------------------------------
// bcd_disp_arbiter
//
// Shares one combinational 11-bit binary-to-BCD converter between two
// requesters using round-robin arbitration. Each channel keeps its last
// 4-digit BCD result. The selected channel is time-multiplexed onto a
// 4-digit 7-segment interface (active-low anodes plus a BCD nibble that an
// external segment decoder turns into segments).
//
// Optional feature: define BLANK_LEADING_ZERO_EN to blank leading zeros of
// the displayed value (the anode is held off; the nibble still carries 0).
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   val0/val1    channel operands, 0..2047
//   vld0/vld1    channel request valid
//   rdy0/rdy1    channel accept (combinational, IDLE only, winner only)
//   done[1:0]    one-cycle pulse, bit n = channel n result written
//   sel          channel shown on the display / bcd_sel
//   bcd_sel      {thousands, hundreds, tens, ones} of the selected channel
//   an[3:0]      registered active-low anodes, an[0] = ones digit
//   digit[3:0]   registered BCD nibble for the lit anode
// -----------------------------------------------------------------------------
module bcd_disp_arbiter #(
  parameter int REFRESH_BITS = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] val0,
  input  logic        vld0,
  output logic        rdy0,
  input  logic [10:0] val1,
  input  logic        vld1,
  output logic        rdy1,
  output logic [1:0]  done,
  input  logic        sel,
  output logic [15:0] bcd_sel,
  output logic [3:0]  an,
  output logic [3:0]  digit
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e                  state_q, state_d;
  logic                    last_q, last_d;    // channel served most recently
  logic                    grant_q, grant_d;
  logic [10:0]             opnd_q, opnd_d;
  logic                    wr_en;
  logic [15:0]             res0_q, res1_q;
  logic [15:0]             conv;
  logic [REFRESH_BITS-1:0] cnt_q;
  logic [1:0]              scan_idx;
  logic [3:0]              an_q, an_d;
  logic [3:0]              digit_q, digit_d;

  // Shift-and-add-3 (double dabble) conversion of an 11-bit value.
  function automatic logic [15:0] bin2bcd(input logic [10:0] bin);
    logic [26:0] sh;
    sh = {16'd0, bin};
    for (int i = 0; i < 11; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sh[11+4*d +: 4] >= 4'd5) sh[11+4*d +: 4] = sh[11+4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    return sh[26:11];
  endfunction

  assign conv = bin2bcd(opnd_q);

  // Arbitration FSM: next state and outputs.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    logic win;
    win     = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    opnd_d  = opnd_q;
    wr_en   = 1'b0;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    done    = 2'b00;
    case (state_q)
      IDLE: begin
        if (vld0 || vld1) begin
          // Both valid: the channel not served last wins.
          win     = (vld0 && vld1) ? ~last_q : vld1;
          rdy0    = ~win;
          rdy1    = win;
          grant_d = win;
          opnd_d  = win ? val1 : val0;
          state_d = CONV;
        end
      end
      CONV: begin
        wr_en   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done[grant_q] = 1'b1;
        last_d        = grant_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake and pulse outputs are quiet while reset is held.
    if (reset) begin
      rdy0 = 1'b0;
      rdy1 = 1'b0;
      done = 2'b00;
    end
  end

  assign bcd_sel  = sel ? res1_q : res0_q;
  assign scan_idx = cnt_q[REFRESH_BITS-1 -: 2];

  // Display: anode and nibble for the digit the scan counter points at.
  always_comb begin
    an_d           = 4'b1111;
    an_d[scan_idx] = 1'b0;
    case (scan_idx)
      2'd0:    digit_d = bcd_sel[3:0];
      2'd1:    digit_d = bcd_sel[7:4];
      2'd2:    digit_d = bcd_sel[11:8];
      default: digit_d = bcd_sel[15:12];
    endcase
`ifdef BLANK_LEADING_ZERO_EN
    // A digit is a leading zero when it and every digit above it are 0.
    // The ones digit is never blanked.
    case (scan_idx)
      2'd3:    if (bcd_sel[15:12] == 4'd0) an_d = 4'b1111;
      2'd2:    if (bcd_sel[15:8]  == 8'd0) an_d = 4'b1111;
      2'd1:    if (bcd_sel[15:4]  == 12'd0) an_d = 4'b1111;
      default: ;
    endcase
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the result registers are cleared too; reset discards any
      // in-flight conversion and all stored results.
      state_q <= IDLE;
      last_q  <= 1'b1;   // so channel 0 wins the first tie
      grant_q <= 1'b0;
      opnd_q  <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
      cnt_q   <= '0;
      an_q    <= 4'b1111;
      digit_q <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      opnd_q  <= opnd_d;
      if (wr_en) begin
        if (grant_q) res1_q <= conv;
        else         res0_q <= conv;
      end
      cnt_q   <= cnt_q + REFRESH_BITS'(1);
      an_q    <= an_d;
      digit_q <= digit_d;
    end
  end

  assign an    = an_q;
  assign digit = digit_q;

endmodule

// File: tb/tb_bcd_disp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bcd_disp_arbiter
//
// Scoreboard bench for bcd_disp_arbiter (REFRESH_BITS=4). A negedge monitor
// models arbitration, the 2-cycle done latency, the result registers and the
// display scan; accepted requests are queued with their expected BCD value and
// popped when done is due. Directed sequences exercise the listed scenarios.
// -----------------------------------------------------------------------------
module tb_bcd_disp_arbiter;

  localparam int RB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] val0 = '0, val1 = '0;
  logic        vld0 = 1'b0, vld1 = 1'b0;
  logic        rdy0, rdy1;
  logic [1:0]  done;
  logic        sel = 1'b0;
  logic [15:0] bcd_sel;
  logic [3:0]  an, digit;

  int checks = 0;
  int failures = 0;

  bcd_disp_arbiter #(.REFRESH_BITS(RB)) dut (
    .clk(clk), .reset(reset),
    .val0(val0), .vld0(vld0), .rdy0(rdy0),
    .val1(val1), .vld1(vld1), .rdy1(rdy1),
    .done(done), .sel(sel), .bcd_sel(bcd_sel),
    .an(an), .digit(digit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // ---------------------------------------------------------------- monitor
  typedef struct {
    bit          ch;
    logic [15:0] bcd;
    int          acc;
  } item_t;

  item_t          sb[$];
  logic [15:0]    m_res [2];
  bit             m_last;
  int             cyc = 0;
  int             idle_cyc = 0;
  logic [RB-1:0]  m_cnt, p_cnt;
  logic [15:0]    p_val;
  bit             p_rst;

  always @(negedge clk) begin
    logic [1:0]  exp_done;
    logic        exp_r0, exp_r1;
    logic [1:0]  idx;
    logic [3:0]  exp_an, exp_dig;
    cyc++;
    if (reset) begin
      check("rst_rdy0", rdy0, 0);
      check("rst_rdy1", rdy1, 0);
      check("rst_done", done, 0);
      sb.delete();
      m_res[0] = '0;
      m_res[1] = '0;
      m_last   = 1'b1;
      idle_cyc = cyc + 1;
      m_cnt    = '0;
      p_rst    = 1'b1;
    end else begin
      exp_done = 2'b00;
      if (sb.size() > 0 && sb[0].acc + 2 == cyc) begin
        exp_done[sb[0].ch] = 1'b1;
        m_res[sb[0].ch]    = sb[0].bcd;
        m_last             = sb[0].ch;
        void'(sb.pop_front());
      end
      check("done", done, exp_done);

      exp_r0 = 1'b0;
      exp_r1 = 1'b0;
      if (cyc >= idle_cyc) begin
        if (vld0 && vld1) begin
          if (m_last) exp_r0 = 1'b1; else exp_r1 = 1'b1;
        end else begin
          exp_r0 = vld0;
          exp_r1 = vld1;
        end
      end
      check("rdy0", rdy0, exp_r0);
      check("rdy1", rdy1, exp_r1);
      check("rdy_excl", rdy0 & rdy1, 0);
      if (exp_r0) begin
        sb.push_back('{ch: 1'b0, bcd: to_bcd(int'(val0)), acc: cyc});
        idle_cyc = cyc + 3;
      end else if (exp_r1) begin
        sb.push_back('{ch: 1'b1, bcd: to_bcd(int'(val1)), acc: cyc});
        idle_cyc = cyc + 3;
      end

      check("bcd_sel", bcd_sel, m_res[sel]);

      // an/digit were registered from the previous cycle's counter and value.
      if (p_rst) begin
        exp_an  = 4'b1111;
        exp_dig = 4'd0;
      end else begin
        idx          = p_cnt[RB-1 -: 2];
        exp_dig      = p_val[{idx, 2'b00} +: 4];
        exp_an       = 4'b1111;
        exp_an[idx]  = 1'b0;
`ifdef BLANK_LEADING_ZERO_EN
        if (idx == 2'd3 && p_val[15:12] == 4'd0)  exp_an = 4'b1111;
        if (idx == 2'd2 && p_val[15:8]  == 8'd0)  exp_an = 4'b1111;
        if (idx == 2'd1 && p_val[15:4]  == 12'd0) exp_an = 4'b1111;
`endif
      end
      check("an", an, exp_an);
      check("digit", digit, exp_dig);
      p_rst = 1'b0;
      p_cnt = m_cnt;
      p_val = m_res[sel];
      m_cnt = m_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds vld/val until rdy, returns the number of cycles spent waiting.
  task automatic send(input bit ch, input logic [10:0] v, output int waited);
    waited = 0;
    if (ch) begin vld1 = 1'b1; val1 = v; end
    else    begin vld0 = 1'b1; val0 = v; end
    forever begin
      #1;
      if (ch ? rdy1 : rdy0) break;
      if (waited >= 50) break;
      waited++;
      @(posedge clk);
      #1;
    end
    check("send_bound", waited < 50, 1);
    tick();
    if (ch) vld1 = 1'b0; else vld0 = 1'b0;
  endtask

  task automatic send_n(input bit ch, input logic [10:0] v, input int n);
    int w;
    repeat (n) send(ch, v, w);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    check("rst_an", an, 4'b1111);
    check("rst_digit", digit, 4'd0);
    check("rst_bcd", bcd_sel, 16'h0000);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    tick();
    do_reset();

    // Single request: accepted at once, done two cycles later.
    sel = 1'b0;
    send(1'b0, 11'd1234, w);
    check("t1_wait", w, 0);
    tick();
    check("t1_done", done, 2'b01);
    tick();
    check("t1_bcd", bcd_sel, 16'h1234);

    // Both channels held: round-robin, starting from the pointer state.
    fork
      send_n(1'b0, 11'd2047, 3);
      send_n(1'b1, 11'd5, 3);
    join
    tick(3);
    sel = 1'b0;
    #1 check("rr_res0", bcd_sel, 16'h2047);
    sel = 1'b1;
    #1 check("rr_res1", bcd_sel, 16'h0005);

    // Request arriving during CONV waits two cycles, then wins on IDLE.
    tick();
    send(1'b0, 11'd42, w);
    send(1'b1, 11'd321, w);
    check("wait_conv", w, 2);
    tick(3);

    // Display scan of 0905 on channel 1, across several counter wraps.
    send(1'b1, 11'd905, w);
    sel = 1'b1;
    tick(40);
    sel = 1'b0;      // mid-scan select change
    tick(9);
    sel = 1'b1;
    tick(7);

    // Reset in the cycle after accepting 999: nothing survives.
    send(1'b1, 11'd999, w);
    do_reset();
    check("rm_bcd1", bcd_sel, 16'h0000);
    tick(6);

    // Leading-zero values on channel 0.
    sel = 1'b0;
    send(1'b0, 11'd7, w);
    tick(20);
    send(1'b0, 11'd0, w);
    tick(20);
    send(1'b0, 11'd1000, w);
    tick(20);

    // Random traffic with dropped requests and select changes.
    for (int i = 0; i < 40; i++) begin
      bit ch;
      ch = 1'($urandom_range(1));
      send(ch, 11'($urandom_range(2047)), w);
      if ($urandom_range(2) == 0) begin
        vld1 = 1'b1;   // short-lived request while busy: dropped
        val1 = 11'($urandom_range(2047));
        tick();
        vld1 = 1'b0;
      end
      if ($urandom_range(3) == 0) sel = ~sel;
      tick($urandom_range(3));
    end
    tick(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
